// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: valid/ready operand intake, one
// full-adder bit per cycle through a carry flop, valid/ready result output.

// One full-adder bit; the controller feeds it the LSBs of the shift registers.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit, co_bit;
  logic             accept, last;

  serial_fa u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s_bit), .co(co_bit));

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // Handshake flags come only from registered state, never from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: IDLE -> SHIFT on accept, SHIFT -> DONE after WIDTH bits,
  // DONE -> IDLE on out handshake (held under backpressure).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept (subtract = A + ~B + 1), then shift one bit per
  // SHIFT cycle. sum/cout are untouched in IDLE and DONE so the result stays
  // stable while presented and until the next operation overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_sr  <= a;
          b_sr  <= op_sub ? ~b : b;
          carry <= op_sub ? 1'b1 : cin;
          cnt   <= '0;
        end
        SHIFT: begin
          sum   <= {s_bit, sum[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= co_bit;
          cnt   <= cnt + CNT_W'(1);
          if (last) cout <= co_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: directed sequence on a WIDTH=4 instance, random sweep
// on a WIDTH=8 instance checked against plain-arithmetic expected results.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       v4 = 0, r4, sub4 = 0, cin4 = 0, ov4, or4 = 0, cout4, busy4;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  // WIDTH=8 instance
  logic       v8 = 0, r8, sub8 = 0, cin8 = 0, ov8, or8 = 0, cout8, busy8;
  logic [7:0] a8 = 0, b8 = 0, sum8;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
    .cin(cin4), .op_sub(sub4), .out_valid(ov4), .out_ready(or4),
    .sum(sum4), .cout(cout4), .busy(busy4));

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
    .cin(cin8), .op_sub(sub8), .out_valid(ov8), .out_ready(or8),
    .sum(sum8), .cout(cout8), .busy(busy8));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {cout,sum} from the arithmetic definition, modulo 2^(w+1).
  function automatic int model(input int w, input int a, input int b, input int ci, input bit sub);
    int mask = (1 << w) - 1;
    int r    = sub ? a + ((~b) & mask) + 1 : a + b + ci;
    return r & ((1 << (w + 1)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sub);
    v4 = 1; a4 = a; b4 = b; cin4 = ci; sub4 = sub;
    tick();
    v4 = 0;
  endtask

  // Called just after the accept edge; counts edges until out_valid.
  task automatic wait4(output int lat, input bit watch);
    lat = 0;
    while (ov4 !== 1'b1 && lat < 40) begin
      if (watch) begin
        chk("busy_in_shift", 32'(busy4), 32'd1);
        chk("in_ready_low_in_shift", 32'(r4), 32'd0);
      end
      tick(); lat++;
    end
  endtask

  task automatic ack4();
    or4 = 1; tick(); or4 = 0;
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input logic sub, input int exp_sum, input int exp_cout);
    int lat;
    send4(a, b, ci, sub);
    wait4(lat, 1'b1);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(sum4), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout4), 32'(exp_cout));
    chk({tag, "_model"}, 32'({cout4, sum4}), 32'(model(4, a, b, ci, sub)));
    chk({tag, "_busy_done"}, 32'(busy4), 32'd1);
    chk({tag, "_in_ready_done"}, 32'(r4), 32'd0);
    ack4();
    chk({tag, "_in_ready_after"}, 32'(r4), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy4), 32'd0);
    chk({tag, "_ov_after"}, 32'(ov4), 32'd0);
  endtask

  initial begin
    int lat;
    logic [3:0] s_hold;
    logic       c_hold;

    // Reset state
    rst = 1; tick(); tick(); rst = 0;
    chk("rst_in_ready", 32'(r4), 32'd1);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_sum", 32'(sum4), 32'd0);
    chk("rst_cout", 32'(cout4), 32'd0);

    // Directed arithmetic
    run4("add_5_3", 4'd5, 4'd3, 1'b0, 1'b0, 8, 0);
    run4("add_7_8_c1", 4'd7, 4'd8, 1'b1, 1'b0, 0, 1);
    run4("add_15_1", 4'd15, 4'd1, 1'b0, 1'b0, 0, 1);
    run4("sub_3_5", 4'd3, 4'd5, 1'b1, 1'b1, 14, 0);
    run4("sub_9_4", 4'd9, 4'd4, 1'b0, 1'b1, 5, 1);

    // Backpressure with requests pulsed during SHIFT and DONE
    send4(4'd13, 4'd6, 1'b0, 1'b0);
    v4 = 1; a4 = 4'd1; b4 = 4'd1; cin4 = 0; sub4 = 0;
    wait4(lat, 1'b0);
    chk("bp_latency", 32'(lat), 32'd4);
    chk("bp_sum", 32'(sum4), 32'd3);
    chk("bp_cout", 32'(cout4), 32'd1);
    s_hold = sum4; c_hold = cout4;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(ov4), 32'd1);
      chk("bp_hold_sum", 32'(sum4), 32'(s_hold));
      chk("bp_hold_cout", 32'(cout4), 32'(c_hold));
    end
    or4 = 1; tick(); or4 = 0;
    chk("bp_release_idle", 32'(r4), 32'd1);
    chk("bp_release_ov", 32'(ov4), 32'd0);
    tick(); v4 = 0;  // in_valid still high: accepted on this edge
    chk("b2b_accepted_busy", 32'(busy4), 32'd1);
    wait4(lat, 1'b1);
    chk("b2b_latency", 32'(lat), 32'd4);
    chk("b2b_sum", 32'(sum4), 32'd2);
    chk("b2b_cout", 32'(cout4), 32'd0);
    ack4();

    // Reset during the 2nd SHIFT cycle
    send4(4'd6, 4'd6, 1'b0, 1'b0);
    tick();
    rst = 1; tick(); rst = 0;
    chk("mrst_in_ready", 32'(r4), 32'd1);
    chk("mrst_out_valid", 32'(ov4), 32'd0);
    chk("mrst_busy", 32'(busy4), 32'd0);
    chk("mrst_sum", 32'(sum4), 32'd0);
    chk("mrst_cout", 32'(cout4), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_no_result", 32'(ov4), 32'd0);
    end
    run4("after_rst_2_2", 4'd2, 4'd2, 1'b0, 1'b0, 4, 0);

    // Random sweep at WIDTH=8
    for (int n = 0; n < 240; n++) begin
      int ra, rb, rc, exp;
      bit rs;
      ra = int'($urandom_range(255)); rb = int'($urandom_range(255));
      rc = int'($urandom_range(1));   rs = 1'($urandom_range(1));
      exp = model(8, ra, rb, rc, rs);
      v8 = 1; a8 = 8'(ra); b8 = 8'(rb); cin8 = 1'(rc); sub8 = rs;
      tick(); v8 = 0;
      lat = 0;
      while (ov8 !== 1'b1 && lat < 40) begin tick(); lat++; end
      chk("w8_latency", 32'(lat), 32'd8);
      chk("w8_result", 32'({cout8, sum8}), 32'(exp));
      or8 = 1; tick(); or8 = 0;
      chk("w8_idle", 32'(r8), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
